// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    LU_STALL = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int CNT_W_DEFAULT   = 32;

  // Load-use hazard: the load in EX writes a non-zero register that the
  // instruction in ID actually reads through rs1 or rs2.
  function automatic logic loadUseHazard(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1Use,
    input logic [4:0] rs2,
    input logic       rs2Use
  );
    return memread && (rd != 5'd0) &&
           ((rs1Use && (rs1 == rd)) || (rs2Use && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the sequencer's pipeline-side signals; the sequencer is the slave.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [4:0]       rs1_id_i;
  logic [4:0]       rs2_id_i;
  logic             rs1_use_i;
  logic             rs2_use_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic             branch_taken_i;
  logic             dmem_busy_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_freeze_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] lu_stalls_o;
  logic             mem_timeout_o;

  modport slave (
    input  start_i, rs1_id_i, rs2_id_i, rs1_use_i, rs2_use_i,
           idex_memread_i, idex_rd_i, branch_taken_i, dmem_busy_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           pipe_freeze_o, stall_cycles_o, lu_stalls_o, mem_timeout_o
  );

  modport master (
    output start_i, rs1_id_i, rs2_id_i, rs1_use_i, rs2_use_i,
           idex_memread_i, idex_rd_i, branch_taken_i, dmem_busy_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           pipe_freeze_o, stall_cycles_o, lu_stalls_o, mem_timeout_o
  );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // Count one per enabled cycle until the counter is full, then hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use bubbles, memory freezes, branch flush gating,
// start/halt control and stall performance counters.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input logic                 clk_i,
  input logic                 rst_i,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_timeout;

  logic w_lu;
  logic w_pcWrite;
  logic w_ifidWrite;
  logic w_flush;
  logic w_bubble;
  logic w_freeze;
  logic w_active;
  logic w_stallInc;

  assign w_lu = loadUseHazard(bus.idex_memread_i, bus.idex_rd_i,
                              bus.rs1_id_i, bus.rs1_use_i,
                              bus.rs2_id_i, bus.rs2_use_i);

  assign w_active = (r_state == RUN) || (r_state == LU_STALL) || (r_state == MEM_WAIT);

  // Zero-latency control decode: busy beats a hazard, a hazard beats advancing,
  // and a hazard suppresses the flush because the branch saw a stale operand.
  always_comb begin
    w_pcWrite   = 1'b0;
    w_ifidWrite = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    w_freeze    = 1'b1;
    if (w_active && !bus.dmem_busy_i) begin
      if (w_lu && (r_state != LU_STALL)) begin
        w_bubble = 1'b1;
        w_freeze = 1'b0;
      end else begin
        w_pcWrite   = 1'b1;
        w_ifidWrite = 1'b1;
        w_freeze    = 1'b0;
        w_flush     = bus.branch_taken_i;
      end
    end
  end

  // Sequencer state, memory-wait timer and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start_i) r_state <= RUN;
        end
        RUN, LU_STALL: begin
          if (bus.dmem_busy_i) begin
            r_state   <= MEM_WAIT;
            r_waitCnt <= '0;
          end else begin
            r_state <= w_bubble ? LU_STALL : RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_busy_i) begin
            if (r_waitCnt == WAIT_W'(TIMEOUT - 1)) begin
              r_state   <= HALT;
              r_timeout <= 1'b1;
            end else begin
              r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
          end else begin
            r_state <= w_bubble ? LU_STALL : RUN;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_stallInc = w_active && !w_pcWrite;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stallInc),
    .cnt_o (bus.stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_luCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_bubble),
    .cnt_o (bus.lu_stalls_o)
  );

  assign bus.pc_write_o    = w_pcWrite;
  assign bus.ifid_write_o  = w_ifidWrite;
  assign bus.ifid_flush_o  = w_flush;
  assign bus.idex_bubble_o = w_bubble;
  assign bus.pipe_freeze_o = w_freeze;
  assign bus.mem_timeout_o = r_timeout;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl with a flag-based reference model.
module tb_hazard_stall_ctrl;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 4;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  typedef struct {
    int pcWrite;
    int ifidWrite;
    int flush;
    int bubble;
    int freeze;
    int stallCycles;
    int luStalls;
    int timeout;
  } expect_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  expect_t expQ[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: the core is described by a few plain facts rather than states.
  bit  mStarted  = 0;
  bit  mHalted   = 0;
  bit  mResolve  = 0;
  int  mWait     = -1;
  int  mStall    = 0;
  int  mLu       = 0;
  bit  mTimeout  = 0;

  hazard_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus();

  hazard_stall_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs at the falling edge, then queue what the model expects.
  task automatic applyStimulus(input bit rst, input bit start, input bit busy,
                               input bit memread, input logic [4:0] rd,
                               input logic [4:0] rs1, input bit use1,
                               input logic [4:0] rs2, input bit use2,
                               input bit branch);
    expect_t e;
    bit hazard;
    @(negedge clk_i);
    rst_i              = rst;
    bus.start_i        = start;
    bus.dmem_busy_i    = busy;
    bus.idex_memread_i = memread;
    bus.idex_rd_i      = rd;
    bus.rs1_id_i       = rs1;
    bus.rs1_use_i      = use1;
    bus.rs2_id_i       = rs2;
    bus.rs2_use_i      = use2;
    bus.branch_taken_i = branch;
    #1;
    hazard = memread && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    e.pcWrite = 0; e.ifidWrite = 0; e.flush = 0; e.bubble = 0; e.freeze = 1;
    if (!rst) begin
      mStarted = 0; mHalted = 0; mResolve = 0; mWait = -1;
      mStall = 0; mLu = 0; mTimeout = 0;
    end
    e.stallCycles = mStall;
    e.luStalls    = mLu;
    e.timeout     = mTimeout;
    if (!rst) begin
    end else if (!mStarted) begin
      if (start) mStarted = 1;
    end else if (mHalted) begin
    end else if (busy) begin
      mStall   = (mStall < CNT_MAX) ? mStall + 1 : mStall;
      mResolve = 0;
      if (mWait < 0) begin
        mWait = 0;
      end else begin
        mWait++;
        if (mWait == TB_TIMEOUT) begin
          mHalted  = 1;
          mTimeout = 1;
        end
      end
    end else begin
      mWait = -1;
      if (hazard && !mResolve) begin
        e.bubble = 1;
        e.freeze = 0;
        mStall   = (mStall < CNT_MAX) ? mStall + 1 : mStall;
        mLu      = (mLu < CNT_MAX) ? mLu + 1 : mLu;
        mResolve = 1;
      end else begin
        e.pcWrite   = 1;
        e.ifidWrite = 1;
        e.freeze    = 0;
        e.flush     = branch;
        mResolve    = 0;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic compareField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    compareField("pc_write",     int'(bus.pc_write_o),     e.pcWrite);
    compareField("ifid_write",   int'(bus.ifid_write_o),   e.ifidWrite);
    compareField("ifid_flush",   int'(bus.ifid_flush_o),   e.flush);
    compareField("idex_bubble",  int'(bus.idex_bubble_o),  e.bubble);
    compareField("pipe_freeze",  int'(bus.pipe_freeze_o),  e.freeze);
    compareField("stall_cycles", int'(bus.stall_cycles_o), e.stallCycles);
    compareField("lu_stalls",    int'(bus.lu_stalls_o),    e.luStalls);
    compareField("mem_timeout",  int'(bus.mem_timeout_o),  e.timeout);
  endtask

  // Monitor: pop and compare once per cycle, well before the next rising edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Hard stop in case the stimulus process never finishes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic busyCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetAndStart();
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int drain;
    bus.start_i = 0; bus.dmem_busy_i = 0; bus.idex_memread_i = 0;
    bus.idex_rd_i = 0; bus.rs1_id_i = 0; bus.rs1_use_i = 0;
    bus.rs2_id_i = 0; bus.rs2_use_i = 0; bus.branch_taken_i = 0;

    // Reset, start, first advance.
    resetAndStart();
    idle(2);

    // Load-use on rs1, then the masked resolve cycle, then plain advance.
    applyStimulus(1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    applyStimulus(1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
    idle(1);

    // Load into x0 never stalls; load-use on rs2 with a taken branch.
    applyStimulus(1, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 1);
    applyStimulus(1, 0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 1, 1);
    applyStimulus(1, 0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 1, 1);
    idle(1);

    // Busy for four cycles, dropping straight into a load-use.
    busyCycles(4);
    applyStimulus(1, 0, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1);
    idle(2);

    // Busy, lu and branch together: busy wins.
    applyStimulus(1, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, 1);
    idle(1);

    // Timeout: busy long enough to halt, then release busy; start is ignored.
    busyCycles(20);
    applyStimulus(1, 1, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, 1);
    idle(3);

    // Reset during a memory wait.
    resetAndStart();
    busyCycles(3);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    resetAndStart();

    // Saturate the load-use counter.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0);
      applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    end

    // Randomized traffic with occasional resets and long busy bursts.
    for (int i = 0; i < 1500; i++) begin
      bit rst, start, busy, memread, use1, use2, branch;
      logic [4:0] rd, rs1, rs2;
      rst     = ($urandom_range(0, 99) >= 2);
      start   = ($urandom_range(0, 99) < 30);
      busy    = ($urandom_range(0, 99) < 30);
      memread = ($urandom_range(0, 1) == 1);
      use1    = ($urandom_range(0, 1) == 1);
      use2    = ($urandom_range(0, 1) == 1);
      branch  = ($urandom_range(0, 1) == 1);
      rd      = 5'($urandom_range(0, 3));
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) begin
        busyCycles($urandom_range(5, 12));
      end
      applyStimulus(rst, start, busy, memread, rd, rs1, use1, rs2, use2, branch);
    end

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(negedge clk_i);
      drain++;
    end
    #5;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
